// File: rtl/atrp_tx_gen_pkg.sv
// Shared definitions for the trapezoid transmit generator: state codes,
// DAC mid-scale and the saturating level step used on every ramp.
package atrp_pkg;

  localparam int W = 12;

  // Level is carried as a 13-bit signed value so ramps never wrap.
  localparam int LW = 13;
  localparam logic signed [LW-1:0] MID = 13'sd2048;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_TOP  = 3'd2,
    ST_FALL = 3'd3,
    ST_BOT  = 3'd4,
    ST_RET  = 3'd5
  } state_e;

  // One ramp step towards lim, clamped so it never overshoots lim.
  function automatic logic signed [LW-1:0] sat_step(
    input logic signed [LW-1:0] lvl,
    input logic        [7:0]    step,
    input logic signed [LW-1:0] lim,
    input logic                 up
  );
    logic signed [LW-1:0] st;
    logic signed [LW-1:0] s;
    st = $signed({5'd0, step});
    if (up) begin
      s = lvl + st;
      if (s > lim) s = lim;
    end else begin
      s = lvl - st;
      if (s < lim) s = lim;
    end
    return s;
  endfunction

endpackage

// File: rtl/atrp_tx_gen_if.sv
// Control inputs and DAC/status outputs of the trapezoid generator.
interface atrp_tx_gen_if #(
  parameter int W = atrp_pkg::W
);
  logic [5:0]   M;
  logic [10:0]  amp;
  logic [W-1:0] TXA;
  logic         en_TX;
  logic [7:0]   N_TX;
  logic         busy;
  logic [2:0]   phase;

  modport master (
    output M, amp,
    input  TXA, en_TX, N_TX, busy, phase
  );

  modport slave (
    input  M, amp,
    output TXA, en_TX, N_TX, busy, phase
  );
endinterface

// File: rtl/atrp_tx_gen_tick_div.sv
// Sample-tick prescaler: tick is high for one clk every DIV clks,
// and constantly high when DIV is 1.
module atrp_tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Count 0..DIV-1 and restart on the tick clk.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/atrp_tx_gen.sv
// Bipolar trapezoid generator: RISE/TOP/FALL/BOT loop around mid-scale,
// draining through RET when the mode goes to zero. Marks each period start
// with a one-clk en_TX pulse and an 8-bit period count.
module atrp_tx_gen #(
  parameter int W       = atrp_pkg::W,
  parameter int STEP    = 16,
  parameter int DIV     = 1,
  parameter int HOLD_SH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  atrp_tx_gen_if.slave  bus
);
  import atrp_pkg::*;

  localparam int HW = 6 + HOLD_SH;
  localparam logic [7:0] STEP_B = 8'(STEP);

  logic tick;

  state_e               state_q, state_d;
  logic signed [LW-1:0] level_q, level_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [5:0]           mq_q, mq_d;
  logic [10:0]          aq_q, aq_d;
  logic                 en_q, en_d;
  logic [7:0]           ntx_q, ntx_d;
  logic [W-1:0]         txa_q, txa_d;

  logic signed [LW-1:0] pos_lim;
  logic signed [LW-1:0] neg_lim;
  logic signed [LW-1:0] step_res;
  logic signed [LW-1:0] txa_w;
  logic [HW-1:0]        hold_load;

  atrp_tick_div #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign pos_lim   = $signed({2'b00, aq_q});
  assign neg_lim   = -pos_lim;
  assign hold_load = HW'(mq_q) << HOLD_SH;
  assign txa_w     = MID + level_d;

  // Next-state, level, hold and period-start logic; only moves on a tick.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    hold_d   = hold_q;
    mq_d     = mq_q;
    aq_d     = aq_q;
    en_d     = 1'b0;
    ntx_d    = ntx_q;
    step_res = '0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          level_d = '0;
          if (bus.M != 6'd0) begin
            mq_d    = bus.M;
            aq_d    = bus.amp;
            state_d = ST_RISE;
            en_d    = 1'b1;
            ntx_d   = ntx_q + 8'd1;
          end
        end
        ST_RISE: begin
          step_res = sat_step(level_q, STEP_B, pos_lim, 1'b1);
          level_d  = step_res;
          if (step_res == pos_lim) begin
            state_d = ST_TOP;
            hold_d  = hold_load;
          end
        end
        ST_TOP: begin
          if (hold_q <= HW'(1)) state_d = ST_FALL;
          else                  hold_d  = hold_q - HW'(1);
        end
        ST_FALL: begin
          step_res = sat_step(level_q, STEP_B, neg_lim, 1'b0);
          level_d  = step_res;
          if (step_res == neg_lim) begin
            state_d = ST_BOT;
            hold_d  = hold_load;
          end
        end
        ST_BOT: begin
          if (hold_q <= HW'(1)) begin
            // End of period: live M decides between draining and relatching.
            if (bus.M == 6'd0) begin
              state_d = ST_RET;
            end else begin
              mq_d    = bus.M;
              aq_d    = bus.amp;
              state_d = ST_RISE;
              en_d    = 1'b1;
              ntx_d   = ntx_q + 8'd1;
            end
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        ST_RET: begin
          step_res = sat_step(level_q, STEP_B, '0, 1'b1);
          level_d  = step_res;
          if (step_res == '0) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      endcase
    end
    txa_d = txa_w[W-1:0];
  end

  // State, level and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      hold_q  <= '0;
      mq_q    <= '0;
      aq_q    <= '0;
      en_q    <= 1'b0;
      ntx_q   <= '0;
      txa_q   <= MID[W-1:0];
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      mq_q    <= mq_d;
      aq_q    <= aq_d;
      en_q    <= en_d;
      ntx_q   <= ntx_d;
      txa_q   <= txa_d;
    end
  end

  assign bus.TXA   = txa_q;
  assign bus.en_TX = en_q;
  assign bus.N_TX  = ntx_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.phase = state_q;

endmodule

// File: tb/tb_atrp_tx_gen.sv
// Directed bench for atrp_tx_gen: three instances (base, full-scale step,
// divided tick) share reset and controls; sel picks the one under test.
module tb_atrp_tx_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  m_in;
  logic [10:0] amp_in;
  logic [1:0]  sel;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  atrp_tx_gen_if #(.W(12)) if_a ();
  atrp_tx_gen_if #(.W(12)) if_b ();
  atrp_tx_gen_if #(.W(12)) if_c ();

  assign if_a.M = m_in;  assign if_a.amp = amp_in;
  assign if_b.M = m_in;  assign if_b.amp = amp_in;
  assign if_c.M = m_in;  assign if_c.amp = amp_in;

  atrp_tx_gen #(.W(12), .STEP(16),  .DIV(1), .HOLD_SH(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  atrp_tx_gen #(.W(12), .STEP(255), .DIV(1), .HOLD_SH(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  atrp_tx_gen #(.W(12), .STEP(16),  .DIV(4), .HOLD_SH(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [11:0] cur_txa;
  logic        cur_en;
  logic [7:0]  cur_ntx;
  logic        cur_busy;
  logic [2:0]  cur_phase;

  always_comb begin
    case (sel)
      2'd1:    begin cur_txa = if_b.TXA; cur_en = if_b.en_TX; cur_ntx = if_b.N_TX; cur_busy = if_b.busy; cur_phase = if_b.phase; end
      2'd2:    begin cur_txa = if_c.TXA; cur_en = if_c.en_TX; cur_ntx = if_c.N_TX; cur_busy = if_c.busy; cur_phase = if_c.phase; end
      default: begin cur_txa = if_a.TXA; cur_en = if_a.en_TX; cur_ntx = if_a.N_TX; cur_busy = if_a.busy; cur_phase = if_a.phase; end
    endcase
  end

  // Walk one period from the current en_TX clk up to the next en_TX clk,
  // collecting length, extremes, per-phase clk counts and TXA changes.
  // Optionally changes M at clk offset set_at.
  task automatic measure(input int set_at, input logic [5:0] set_m,
                         output int n, output int hi, output int lo,
                         output int rise_n, output int top_n, output int fall_n,
                         output int bot_n, output int chg, output int en_n);
    int prev;
    n = 0; hi = 0; lo = 4096; rise_n = 0; top_n = 0; fall_n = 0; bot_n = 0; chg = 0; en_n = 0;
    prev = int'(cur_txa);
    while (1) begin
      if (int'(cur_txa) > hi) hi = int'(cur_txa);
      if (int'(cur_txa) < lo) lo = int'(cur_txa);
      case (cur_phase)
        3'd1: rise_n++;
        3'd2: top_n++;
        3'd3: fall_n++;
        3'd4: bot_n++;
        default: ;
      endcase
      if (cur_en) en_n++;
      if (n == set_at) m_in = set_m;
      @(negedge clk);
      n++;
      if (int'(cur_txa) != prev) chg++;
      prev = int'(cur_txa);
      if (cur_en) break;
      if (n >= 2000) begin
        vec_cnt++; err_cnt++;
        $display("FAIL period_timeout: got no en_TX after %0d clks, want one", n);
        break;
      end
    end
    $display("period: clks=%0d rise=%0d top=%0d fall=%0d bot=%0d hi=%0d lo=%0d chg=%0d N_TX=%0d",
             n, rise_n, top_n, fall_n, bot_n, hi, lo, chg, cur_ntx);
  endtask

  task automatic test_reset();
    sel = 2'd0; m_in = 6'd1; amp_in = 11'd256; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++; if (cur_txa !== 12'd2048) begin err_cnt++; $display("FAIL rst_txa: got %0d want 2048", cur_txa); end
    vec_cnt++; if (cur_en !== 1'b0) begin err_cnt++; $display("FAIL rst_en: got %0b want 0", cur_en); end
    vec_cnt++; if (cur_ntx !== 8'd0) begin err_cnt++; $display("FAIL rst_ntx: got %0d want 0", cur_ntx); end
    vec_cnt++; if (cur_busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %0b want 0", cur_busy); end
    vec_cnt++; if (cur_phase !== 3'd0) begin err_cnt++; $display("FAIL rst_phase: got %0d want 0", cur_phase); end
    $display("reset: TXA=%0d en=%0b N_TX=%0d busy=%0b phase=%0d", cur_txa, cur_en, cur_ntx, cur_busy, cur_phase);
  endtask

  task automatic test_basic();
    int n, hi, lo, r, t, f, b, c, e;
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++; if (cur_en !== 1'b1) begin err_cnt++; $display("FAIL first_en: got %0b want 1", cur_en); end
    vec_cnt++; if (cur_ntx !== 8'd1) begin err_cnt++; $display("FAIL first_ntx: got %0d want 1", cur_ntx); end
    vec_cnt++; if (cur_phase !== 3'd1) begin err_cnt++; $display("FAIL first_phase: got %0d want 1", cur_phase); end
    vec_cnt++; if (cur_txa !== 12'd2048) begin err_cnt++; $display("FAIL first_txa: got %0d want 2048", cur_txa); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 64) begin err_cnt++; $display("FAIL p1_len: got %0d want 64", n); end
    vec_cnt++; if (r != 16) begin err_cnt++; $display("FAIL p1_rise: got %0d want 16", r); end
    vec_cnt++; if (t != 8) begin err_cnt++; $display("FAIL p1_top: got %0d want 8", t); end
    vec_cnt++; if (f != 32) begin err_cnt++; $display("FAIL p1_fall: got %0d want 32", f); end
    vec_cnt++; if (b != 8) begin err_cnt++; $display("FAIL p1_bot: got %0d want 8", b); end
    vec_cnt++; if (hi != 2304) begin err_cnt++; $display("FAIL p1_peak: got %0d want 2304", hi); end
    vec_cnt++; if (lo != 1792) begin err_cnt++; $display("FAIL p1_floor: got %0d want 1792", lo); end
    vec_cnt++; if (cur_ntx !== 8'd2) begin err_cnt++; $display("FAIL p1_ntx: got %0d want 2", cur_ntx); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 80) begin err_cnt++; $display("FAIL p2_len: got %0d want 80", n); end
    vec_cnt++; if (r != 32) begin err_cnt++; $display("FAIL p2_rise: got %0d want 32", r); end
    vec_cnt++; if (c != 64) begin err_cnt++; $display("FAIL p2_changes: got %0d want 64", c); end
    vec_cnt++; if (e != 1) begin err_cnt++; $display("FAIL p2_en_width: got %0d want 1", e); end
    vec_cnt++; if (cur_ntx !== 8'd3) begin err_cnt++; $display("FAIL p2_ntx: got %0d want 3", cur_ntx); end
  endtask

  task automatic test_mchange();
    int n, hi, lo, r, t, f, b, c, e;
    measure(50, 6'd2, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 80) begin err_cnt++; $display("FAIL mchg_cur_len: got %0d want 80", n); end
    vec_cnt++; if (t != 8 || b != 8) begin err_cnt++; $display("FAIL mchg_cur_hold: got top=%0d bot=%0d want 8/8", t, b); end
    vec_cnt++; if (cur_ntx !== 8'd4) begin err_cnt++; $display("FAIL mchg_ntx: got %0d want 4", cur_ntx); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 96) begin err_cnt++; $display("FAIL mchg_next_len: got %0d want 96", n); end
    vec_cnt++; if (t != 16 || b != 16) begin err_cnt++; $display("FAIL mchg_next_hold: got top=%0d bot=%0d want 16/16", t, b); end
  endtask

  task automatic test_stop();
    int n, r, e;
    n = 0;
    while (cur_phase !== 3'd5 && n < 500) begin
      if (n == 35) m_in = 6'd0;
      @(negedge clk);
      n++;
    end
    vec_cnt++; if (n != 96) begin err_cnt++; $display("FAIL stop_ret_entry: got %0d clks want 96", n); end
    vec_cnt++; if (cur_txa !== 12'd1792) begin err_cnt++; $display("FAIL stop_ret_txa: got %0d want 1792", cur_txa); end
    r = 0;
    while (cur_phase !== 3'd0 && r < 100) begin
      @(negedge clk);
      r++;
    end
    vec_cnt++; if (r != 16) begin err_cnt++; $display("FAIL stop_ret_len: got %0d want 16", r); end
    vec_cnt++; if (cur_txa !== 12'd2048) begin err_cnt++; $display("FAIL stop_idle_txa: got %0d want 2048", cur_txa); end
    vec_cnt++; if (cur_busy !== 1'b0) begin err_cnt++; $display("FAIL stop_busy: got %0b want 0", cur_busy); end
    e = 0;
    repeat (150) begin
      @(negedge clk);
      if (cur_en) e++;
    end
    vec_cnt++; if (e != 0) begin err_cnt++; $display("FAIL stop_no_en: got %0d pulses want 0", e); end
    vec_cnt++; if (cur_ntx !== 8'd5) begin err_cnt++; $display("FAIL stop_ntx: got %0d want 5", cur_ntx); end
    $display("stop: ret_entry=%0d ret_len=%0d TXA=%0d busy=%0b", n, r, cur_txa, cur_busy);
  endtask

  task automatic test_fullscale();
    int n, hi, lo, r, t, f, b, c, e;
    sel = 2'd1; rst_n = 1'b0; m_in = 6'd1; amp_in = 11'd2047;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++; if (cur_en !== 1'b1) begin err_cnt++; $display("FAIL fs_first_en: got %0b want 1", cur_en); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (r != 9) begin err_cnt++; $display("FAIL fs_rise0: got %0d want 9", r); end
    vec_cnt++; if (n != 42) begin err_cnt++; $display("FAIL fs_p1_len: got %0d want 42", n); end
    vec_cnt++; if (hi != 4095) begin err_cnt++; $display("FAIL fs_peak: got %0d want 4095", hi); end
    vec_cnt++; if (lo != 1) begin err_cnt++; $display("FAIL fs_floor: got %0d want 1", lo); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 50) begin err_cnt++; $display("FAIL fs_p2_len: got %0d want 50", n); end
    vec_cnt++; if (r != 17 || f != 17) begin err_cnt++; $display("FAIL fs_ramps: got rise=%0d fall=%0d want 17/17", r, f); end
  endtask

  task automatic test_div();
    int n, hi, lo, r, t, f, b, c, e, w;
    sel = 2'd2; rst_n = 1'b0; m_in = 6'd1; amp_in = 11'd64;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!cur_en && w < 20);
    vec_cnt++; if (w != 4) begin err_cnt++; $display("FAIL div_first_en: got %0d clks want 4", w); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 112) begin err_cnt++; $display("FAIL div_p1_len: got %0d want 112", n); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 128) begin err_cnt++; $display("FAIL div_p2_len: got %0d want 128", n); end
    vec_cnt++; if (c != 16) begin err_cnt++; $display("FAIL div_changes: got %0d want 16", c); end
    vec_cnt++; if (e != 1) begin err_cnt++; $display("FAIL div_en_width: got %0d want 1", e); end
    vec_cnt++; if (hi != 2112 || lo != 1984) begin err_cnt++; $display("FAIL div_extremes: got %0d/%0d want 2112/1984", hi, lo); end
  endtask

  task automatic test_async_reset_wrap();
    int n, hi, lo, r, t, f, b, c, e, k, cyc;
    sel = 2'd0; rst_n = 1'b0; m_in = 6'd1; amp_in = 11'd256;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    vec_cnt++; if (cur_phase !== 3'd1 || cur_txa !== 12'd2128) begin err_cnt++; $display("FAIL ar_mid_rise: got phase=%0d TXA=%0d want 1/2128", cur_phase, cur_txa); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (cur_txa !== 12'd2048) begin err_cnt++; $display("FAIL ar_txa: got %0d want 2048", cur_txa); end
    vec_cnt++; if (cur_ntx !== 8'd0) begin err_cnt++; $display("FAIL ar_ntx: got %0d want 0", cur_ntx); end
    vec_cnt++; if (cur_en !== 1'b0 || cur_phase !== 3'd0) begin err_cnt++; $display("FAIL ar_state: got en=%0b phase=%0d want 0/0", cur_en, cur_phase); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++; if (cur_en !== 1'b1 || cur_ntx !== 8'd1) begin err_cnt++; $display("FAIL ar_restart: got en=%0b N_TX=%0d want 1/1", cur_en, cur_ntx); end
    measure(-1, 6'd0, n, hi, lo, r, t, f, b, c, e);
    vec_cnt++; if (n != 64) begin err_cnt++; $display("FAIL ar_p1_len: got %0d want 64", n); end
    k = 2; cyc = 0;
    while (k < 300 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (cur_en) begin
        k++;
        if (k == 255) begin
          vec_cnt++; if (cur_ntx !== 8'd255) begin err_cnt++; $display("FAIL wrap_255: got %0d want 255", cur_ntx); end
        end
        if (k == 256) begin
          vec_cnt++; if (cur_ntx !== 8'd0) begin err_cnt++; $display("FAIL wrap_0: got %0d want 0", cur_ntx); end
        end
      end
    end
    vec_cnt++; if (k != 300) begin err_cnt++; $display("FAIL wrap_timeout: got %0d periods want 300", k); end
    vec_cnt++; if (cur_ntx !== 8'd44) begin err_cnt++; $display("FAIL wrap_300: got %0d want 44", cur_ntx); end
    $display("wrap: periods=%0d N_TX=%0d", k, cur_ntx);
  endtask

  initial begin
    rst_n = 1'b0; m_in = 6'd0; amp_in = 11'd0; sel = 2'd0;
    test_reset();
    test_basic();
    test_mchange();
    test_stop();
    test_fullscale();
    test_div();
    test_async_reset_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
